// File: rtl/load_store_unit.sv
//==============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store sequencer between decode, memory
//               and the register file write port. Optional request timeout
//               (with sticky err output) when LSU_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int RW             = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [RW-1:0] dest_reg,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_enable,
  output logic [RW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
`ifdef LSU_TIMEOUT_EN
  output logic          err,
`endif
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_is_store, w_is_store;
  logic [RW-1:0] r_dest, w_dest;
  logic          w_busy, w_mem_req, w_mem_we, w_wb_enable, w_done;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata, w_wb_data;
  logic [RW-1:0] w_wb_addr;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] c_tlimit = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tcnt, w_tcnt;
  logic       w_err;
`endif

  // Every output is computed one cycle ahead so it leaves a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_is_store  = r_is_store;
    w_dest      = r_dest;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = mem_addr;
    w_mem_wdata = mem_wdata;
    w_wb_enable = 1'b0;
    w_wb_addr   = wb_addr;
    w_wb_data   = wb_data;
    w_done      = 1'b0;
`ifdef LSU_TIMEOUT_EN
    w_tcnt      = r_tcnt;
    w_err       = err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_REQ;
          w_is_store  = is_store;
          w_dest      = dest_reg;
          w_mem_req   = 1'b1;
          w_mem_we    = is_store;
          w_mem_addr  = addr_in;
          w_mem_wdata = wdata_in;
`ifdef LSU_TIMEOUT_EN
          w_tcnt      = 8'd0;
          w_err       = 1'b0;
`endif
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_done = 1'b1;
          if (r_is_store) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_WB;
            w_wb_enable = 1'b1;
            w_wb_addr   = r_dest;
            w_wb_data   = mem_rdata;
          end
`ifdef LSU_TIMEOUT_EN
        end else if (r_tcnt == c_tlimit) begin
          // Abort: finish without writeback and flag the error.
          w_state_nxt = S_FIN;
          w_done      = 1'b1;
          w_err       = 1'b1;
        end else begin
          w_tcnt    = r_tcnt + 8'd1;
          w_mem_req = 1'b1;
          w_mem_we  = r_is_store;
        end
`else
        end else begin
          w_mem_req = 1'b1;
          w_mem_we  = r_is_store;
        end
`endif
      end
      S_WB, S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_dest     <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_enable  <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      done       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_tcnt     <= 8'd0;
      err        <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_is_store <= w_is_store;
      r_dest     <= w_dest;
      busy       <= w_busy;
      mem_req    <= w_mem_req;
      mem_we     <= w_mem_we;
      mem_addr   <= w_mem_addr;
      mem_wdata  <= w_mem_wdata;
      wb_enable  <= w_wb_enable;
      wb_addr    <= w_wb_addr;
      wb_data    <= w_wb_data;
      done       <= w_done;
`ifdef LSU_TIMEOUT_EN
      r_tcnt     <= w_tcnt;
      err        <= w_err;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed and randomized transaction bench for load_store_unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RW = 2;
  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam int MAXD = 2;
`else
  localparam int MAXD = 6;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, is_store, mem_ack;
  logic [RW-1:0] dest_reg;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata_in, mem_rdata;
  logic          busy, mem_req, mem_we, wb_enable, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, wb_data;
  logic [RW-1:0] wb_addr;
`ifdef LSU_TIMEOUT_EN
  logic          err;
  logic          exp_err;
`endif

  int checks = 0;
  int errors = 0;

  // Transaction-level model state: last register write and register contents.
  logic [RW-1:0] exp_wb_addr;
  logic [DW-1:0] exp_wb_data;
  logic [DW-1:0] regfile [4];

  always #5 clk = ~clk;

  load_store_unit #(.DW(DW), .AW(AW), .RW(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .dest_reg(dest_reg), .addr_in(addr_in), .wdata_in(wdata_in),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef LSU_TIMEOUT_EN
    .err(err),
`endif
    .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_inputs();
    start    = 1'($urandom_range(0, 1));
    is_store = 1'($urandom_range(0, 1));
    dest_reg = RW'($urandom);
    addr_in  = AW'($urandom);
    wdata_in = DW'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      32'(busy),      32'(0));
    check({tag, ".mem_req"},   32'(mem_req),   32'(0));
    check({tag, ".mem_we"},    32'(mem_we),    32'(0));
    check({tag, ".wb_enable"}, 32'(wb_enable), 32'(0));
    check({tag, ".done"},      32'(done),      32'(0));
    check({tag, ".wb_addr"},   32'(wb_addr),   32'(exp_wb_addr));
    check({tag, ".wb_data"},   32'(wb_data),   32'(exp_wb_data));
`ifdef LSU_TIMEOUT_EN
    check({tag, ".err"},       32'(err),       32'(exp_err));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_idle(tag);
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(0));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(0));
  endtask

  // One complete access: called in an IDLE cycle, returns in the cycle busy falls.
  task automatic do_op(input bit st, input logic [RW-1:0] d, input logic [AW-1:0] a,
                       input logic [DW-1:0] w, input logic [DW-1:0] r, input int dly);
    start = 1'b1; is_store = st; dest_reg = d; addr_in = a; wdata_in = w; mem_ack = 1'b0;
    tick();
`ifdef LSU_TIMEOUT_EN
    exp_err = 1'b0;
`endif
    for (int k = 0; k <= dly; k++) begin
      check("req.busy",      32'(busy),      32'(1));
      check("req.mem_req",   32'(mem_req),   32'(1));
      check("req.mem_we",    32'(mem_we),    32'(st));
      check("req.mem_addr",  32'(mem_addr),  32'(a));
      check("req.mem_wdata", 32'(mem_wdata), 32'(w));
      check("req.done",      32'(done),      32'(0));
      check("req.wb_enable", 32'(wb_enable), 32'(0));
`ifdef LSU_TIMEOUT_EN
      check("req.err",       32'(err),       32'(0));
`endif
      garbage_inputs();
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? r : DW'($urandom);
      tick();
    end
    if (!st) begin
      exp_wb_addr = d;
      exp_wb_data = r;
      regfile[d]  = r;
    end
    check("fin.busy",      32'(busy),      32'(1));
    check("fin.mem_req",   32'(mem_req),   32'(0));
    check("fin.mem_we",    32'(mem_we),    32'(0));
    check("fin.done",      32'(done),      32'(1));
    check("fin.wb_enable", 32'(wb_enable), 32'(!st));
    check("fin.wb_addr",   32'(wb_addr),   32'(exp_wb_addr));
    check("fin.wb_data",   32'(wb_data),   32'(exp_wb_data));
    garbage_inputs();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    tick();
    start   = 1'b0;
    mem_ack = 1'b0;
    check_idle("post");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; dest_reg = '0; addr_in = '0;
    wdata_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    exp_wb_addr = '0; exp_wb_data = '0;
    for (int i = 0; i < 4; i++) regfile[i] = '0;
`ifdef LSU_TIMEOUT_EN
    exp_err = 1'b0;
`endif
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_idle("idle0");

    // Directed load, ack in the first request cycle.
    do_op(1'b0, 2'd2, 8'h10, 8'h00, 8'h5A, 0);
    tick();
    check_idle("idle1");

    // Directed store, three request cycles, with start pulses while busy.
    do_op(1'b1, 2'd1, 8'h20, 8'hC3, 8'h77, 2);

    // Back-to-back loads started in the cycle busy falls.
    do_op(1'b0, 2'd1, 8'h40, 8'h00, 8'hA1, 1);
    do_op(1'b0, 2'd3, 8'h41, 8'h00, 8'hB2, 0);
    check("regfile1", 32'(regfile[1]), 32'(8'hA1));
    check("regfile3", 32'(regfile[3]), 32'(8'hB2));

    // Reset during the request phase of a load, then a late ack.
    start = 1'b1; is_store = 1'b0; dest_reg = 2'd0; addr_in = 8'h33; wdata_in = 8'h00;
    tick();
    start = 1'b0;
    check("rst.mem_req", 32'(mem_req), 32'(1));
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    exp_wb_addr = '0;
    exp_wb_data = '0;
    check_all_zero("midrst");
    rst_n = 1'b1; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_idle("lateack");
    tick();
    check_idle("lateack2");

`ifdef LSU_TIMEOUT_EN
    // Load with no ack: aborts after TO request cycles.
    start = 1'b1; is_store = 1'b0; dest_reg = 2'd2; addr_in = 8'h55; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("to.mem_req", 32'(mem_req), 32'(1));
      check("to.err",     32'(err),     32'(0));
      tick();
    end
    check("to.done",      32'(done),      32'(1));
    check("to.err_set",   32'(err),       32'(1));
    check("to.wb_enable", 32'(wb_enable), 32'(0));
    check("to.mem_req0",  32'(mem_req),   32'(0));
    exp_err = 1'b1;
    tick();
    check_idle("to.idle");
    do_op(1'b0, 2'd0, 8'h56, 8'h00, 8'h3C, 1);
`endif

    // Randomized accesses with random gaps (zero gap = back-to-back).
    for (int n = 0; n < 40; n++) begin
      int gap;
      do_op(1'($urandom_range(0, 1)), RW'($urandom), AW'($urandom), DW'($urandom),
            DW'($urandom), $urandom_range(0, MAXD));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        tick();
        mem_ack = 1'b0;
        check_idle("gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
